// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared CPU definitions used by the MEM-stage load/store unit.
//   - RV32I load/store funct3 encodings (F3_LB..F3_LHU, F3_SB..F3_SW)
//   - lsu_state_t : load/store unit FSM states
// ---------------------------------------------------------------------------
package cpu_pkg;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_GNT    = 2'd1,
        WAIT_RVALID = 2'd2,
        DONE        = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Purely combinational byte-lane logic for the load/store unit.
//   i_load       : load in MEM stage (already cleared when a store is present)
//   i_store      : store in MEM stage
//   i_funct3     : RV32I access size/sign
//   i_offset     : byte offset within the word (addr[1:0])
//   i_wdata      : store data (rs2)
//   i_rdata      : raw memory word
//   o_be         : store byte enables
//   o_wdata      : store data replicated onto every candidate lane
//   o_rdata_ext  : extracted and sign/zero-extended load data
//   o_fault      : misaligned access or illegal funct3
// ---------------------------------------------------------------------------
module lsu_align
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_load,
    input  logic                  i_store,
    input  logic [2:0]            i_funct3,
    input  logic [1:0]            i_offset,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic [3:0]            o_be,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata_ext,
    output logic                  o_fault
);

    // Pick the addressed byte/half out of the word and extend it to full width.
    function automatic logic [DATA_WIDTH-1:0] extend_load(
        input logic [2:0]            f3,
        input logic [1:0]            off,
        input logic [DATA_WIDTH-1:0] word
    );
        logic [7:0]  v_byte;
        logic [15:0] v_half;
        v_byte = word[{off, 3'b000} +: 8];
        v_half = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_LB:   return {{(DATA_WIDTH-8){v_byte[7]}}, v_byte};
            F3_LBU:  return {{(DATA_WIDTH-8){1'b0}}, v_byte};
            F3_LH:   return {{(DATA_WIDTH-16){v_half[15]}}, v_half};
            F3_LHU:  return {{(DATA_WIDTH-16){1'b0}}, v_half};
            F3_LW:   return word;
            default: return '0;
        endcase
    endfunction

    assign o_rdata_ext = extend_load(i_funct3, i_offset, i_rdata);

    always_comb begin
        o_be    = 4'b0000;
        o_wdata = '0;
        o_fault = 1'b0;
        if (i_store) begin
            case (i_funct3)
                F3_SB: begin
                    o_be    = 4'b0001 << i_offset;
                    o_wdata = {4{i_wdata[7:0]}};
                end
                F3_SH: begin
                    o_fault = i_offset[0];
                    o_be    = 4'b0011 << i_offset;
                    o_wdata = {2{i_wdata[15:0]}};
                end
                F3_SW: begin
                    o_fault = |i_offset;
                    o_be    = 4'b1111;
                    o_wdata = i_wdata;
                end
                default: o_fault = 1'b1;
            endcase
        end else if (i_load) begin
            case (i_funct3)
                F3_LB, F3_LBU: o_fault = 1'b0;
                F3_LH, F3_LHU: o_fault = i_offset[0];
                F3_LW:         o_fault = |i_offset;
                default:       o_fault = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mem_lsu.sv
// ---------------------------------------------------------------------------
// mem_lsu
// MEM-stage load/store unit between the EX/MEM and MEM/WB registers. Turns a
// load/store into a req/gnt/rvalid data-memory transaction and stalls the
// pipeline until it completes.
//   clk, rst                      : clock, synchronous active-high reset
//   memread_m, memwrite_m         : load / store in MEM (both = store)
//   funct3_m, aluresult_m         : access size/sign, byte address
//   writedata_m                   : store data
//   readdata_m                    : extended load data, valid in the DONE cycle
//   stall_m                       : freeze upstream stages while access pending
//   fault_m                       : misaligned / illegal access, suppressed
//   dmem_req/we/addr/be/wdata     : memory request channel
//   dmem_gnt, dmem_rvalid, dmem_rdata : memory handshake and response
// ---------------------------------------------------------------------------
module mem_lsu
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  memread_m,
    input  logic                  memwrite_m,
    input  logic [2:0]            funct3_m,
    input  logic [DATA_WIDTH-1:0] aluresult_m,
    input  logic [DATA_WIDTH-1:0] writedata_m,
    output logic [DATA_WIDTH-1:0] readdata_m,
    output logic                  stall_m,
    output logic                  fault_m,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DATA_WIDTH-1:0] dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic                  dmem_gnt,
    input  logic                  dmem_rvalid,
    input  logic [DATA_WIDTH-1:0] dmem_rdata
);

    lsu_state_t            r_state;
    lsu_state_t            w_next;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_load;
    logic                  w_access;
    logic                  w_fault;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_rdata_ext;

    // A simultaneous read and write is treated as a store.
    assign w_load   = memread_m & ~memwrite_m;
    assign w_access = (memread_m | memwrite_m) & ~w_fault;
    assign fault_m  = w_fault;

    lsu_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .i_load      (w_load),
        .i_store     (memwrite_m),
        .i_funct3    (funct3_m),
        .i_offset    (aluresult_m[1:0]),
        .i_wdata     (writedata_m),
        .i_rdata     (dmem_rdata),
        .o_be        (w_be),
        .o_wdata     (w_wdata),
        .o_rdata_ext (w_rdata_ext),
        .o_fault     (w_fault)
    );

    // Request payload is qualified by access so a faulting or absent op drives zeros.
    assign dmem_we    = w_access & memwrite_m;
    assign dmem_addr  = w_access ? {aluresult_m[DATA_WIDTH-1:2], 2'b00} : '0;
    assign dmem_be    = w_access ? w_be : 4'b0000;
    assign dmem_wdata = w_access ? w_wdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == WAIT_RVALID && dmem_rvalid) begin
                r_rdata <= w_rdata_ext;
            end
        end
    end

    // dmem_req depends only on state and the MEM-stage inputs, never on gnt/rvalid.
    always_comb begin
        w_next     = r_state;
        dmem_req   = 1'b0;
        stall_m    = 1'b0;
        readdata_m = '0;
        case (r_state)
            IDLE, WAIT_GNT: begin
                if (w_access) begin
                    dmem_req = 1'b1;
                    stall_m  = 1'b1;
                    if (dmem_gnt) begin
                        w_next = memwrite_m ? DONE : WAIT_RVALID;
                    end else begin
                        w_next = WAIT_GNT;
                    end
                end else begin
                    w_next = IDLE;
                end
            end
            WAIT_RVALID: begin
                stall_m = 1'b1;
                if (dmem_rvalid) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (w_load) begin
                    readdata_m = r_rdata;
                end
                // The pipeline advances on this edge; the next access starts in IDLE.
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        memread_m;
    logic        memwrite_m;
    logic [2:0]  funct3_m;
    logic [31:0] aluresult_m;
    logic [31:0] writedata_m;
    logic [31:0] readdata_m;
    logic        stall_m;
    logic        fault_m;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    always #5 clk = ~clk;

    mem_lsu #(.DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .memread_m   (memread_m),
        .memwrite_m  (memwrite_m),
        .funct3_m    (funct3_m),
        .aluresult_m (aluresult_m),
        .writedata_m (writedata_m),
        .readdata_m  (readdata_m),
        .stall_m     (stall_m),
        .fault_m     (fault_m),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        int          g;      // cycles before gnt
        int          r;      // cycles from gnt to rvalid (loads)
        logic        fault;
        logic [3:0]  be;
        logic [31:0] wdx;
        logic [31:0] rdx;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb_q[$];
    int          checks = 0;
    int          errors = 0;

    function automatic vec_t mk(logic rd, logic wr, logic [2:0] f3, logic [31:0] addr,
                                logic [31:0] wd, logic [31:0] rdata, int g, int r,
                                logic fault, logic [3:0] be, logic [31:0] wdx, logic [31:0] rdx);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wd = wd; v.rdata = rdata;
        v.g = g; v.r = r; v.fault = fault; v.be = be; v.wdx = wdx; v.rdx = rdx;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        memread_m   = 1'b0;
        memwrite_m  = 1'b0;
        funct3_m    = 3'b000;
        aluresult_m = 32'h0;
        writedata_m = 32'h0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
    endtask

    task automatic run_vec(input int i, input vec_t v);
        logic        load;
        int          last;
        logic [31:0] exp_rd;
        load = v.rd & ~v.wr;
        @(negedge clk);
        memread_m   = v.rd;
        memwrite_m  = v.wr;
        funct3_m    = v.f3;
        aluresult_m = v.addr;
        writedata_m = v.wd;
        dmem_rdata  = v.rdata;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        #1;
        check($sformatf("v%0d_fault", i), {31'b0, fault_m}, {31'b0, v.fault});
        if (v.fault) begin
            check($sformatf("v%0d_fault_req", i), {31'b0, dmem_req}, 32'h0);
            check($sformatf("v%0d_fault_stall", i), {31'b0, stall_m}, 32'h0);
            check($sformatf("v%0d_fault_rdata", i), readdata_m, 32'h0);
            return;
        end
        last = load ? (v.g + v.r + 1) : (v.g + 1);
        if (load) sb_q.push_back(v.rdx);
        for (int k = 0; k <= last; k++) begin
            if (k > 0) begin
                @(negedge clk);
                // stray gnt while waiting for rvalid must be ignored
                dmem_gnt    = (k == v.g) || (load && k > v.g && k < v.g + v.r);
                dmem_rvalid = load && (k == v.g + v.r);
                #1;
            end else begin
                dmem_gnt    = (v.g == 0);
                dmem_rvalid = 1'b0;
                #1;
            end
            if (k < last) begin
                check($sformatf("v%0d_stall_k%0d", i, k), {31'b0, stall_m}, 32'h1);
                check($sformatf("v%0d_req_k%0d", i, k), {31'b0, dmem_req}, {31'b0, (k <= v.g)});
                if (k <= v.g) begin
                    check($sformatf("v%0d_addr_k%0d", i, k), dmem_addr, {v.addr[31:2], 2'b00});
                    check($sformatf("v%0d_we_k%0d", i, k), {31'b0, dmem_we}, {31'b0, v.wr});
                    if (v.wr) begin
                        check($sformatf("v%0d_be_k%0d", i, k), {28'b0, dmem_be}, {28'b0, v.be});
                        check($sformatf("v%0d_wdata_k%0d", i, k), dmem_wdata, v.wdx);
                    end
                end
            end else begin
                check($sformatf("v%0d_done_stall", i), {31'b0, stall_m}, 32'h0);
                check($sformatf("v%0d_done_req", i), {31'b0, dmem_req}, 32'h0);
                if (load) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL v%0d_scoreboard_empty actual=empty expected=entry", i);
                    end else begin
                        exp_rd = sb_q.pop_front();
                        check($sformatf("v%0d_readdata", i), readdata_m, exp_rd);
                    end
                end
            end
        end
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // rd wr f3 addr wd rdata g r fault be wdx rdx
        vecs.push_back(mk(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 0, 4'hF, 32'hDEADBEEF, 32'h0));
        vecs.push_back(mk(0, 1, 3'b000, 32'h103, 32'h123456AB, 32'h0, 2, 0, 0, 4'h8, 32'hABABABAB, 32'h0));
        vecs.push_back(mk(0, 1, 3'b001, 32'h102, 32'h1234CAFE, 32'h0, 1, 0, 0, 4'hC, 32'hCAFECAFE, 32'h0));
        vecs.push_back(mk(0, 1, 3'b000, 32'h101, 32'h0000005A, 32'h0, 0, 0, 0, 4'h2, 32'h5A5A5A5A, 32'h0));
        vecs.push_back(mk(1, 0, 3'b000, 32'h101, 32'h0, 32'h80FF7F01, 0, 1, 0, 4'h0, 32'h0, 32'h0000007F));
        vecs.push_back(mk(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF7F01, 1, 2, 0, 4'h0, 32'h0, 32'hFFFFFF80));
        vecs.push_back(mk(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF7F01, 0, 1, 0, 4'h0, 32'h0, 32'h00000080));
        vecs.push_back(mk(1, 0, 3'b001, 32'h102, 32'h0, 32'h80FF7F01, 3, 2, 0, 4'h0, 32'h0, 32'hFFFF80FF));
        vecs.push_back(mk(1, 0, 3'b101, 32'h102, 32'h0, 32'h80FF7F01, 0, 3, 0, 4'h0, 32'h0, 32'h000080FF));
        vecs.push_back(mk(1, 0, 3'b010, 32'h100, 32'h0, 32'h80FF7F01, 2, 1, 0, 4'h0, 32'h0, 32'h80FF7F01));
        vecs.push_back(mk(1, 0, 3'b000, 32'h102, 32'h0, 32'h80FF7F01, 0, 1, 0, 4'h0, 32'h0, 32'hFFFFFFFF));
        vecs.push_back(mk(1, 0, 3'b001, 32'h200, 32'h0, 32'h1234F00D, 1, 1, 0, 4'h0, 32'h0, 32'hFFFFF00D));
        vecs.push_back(mk(1, 0, 3'b010, 32'h102, 32'h0, 32'h80FF7F01, 0, 1, 1, 4'h0, 32'h0, 32'h0));
        vecs.push_back(mk(1, 0, 3'b011, 32'h100, 32'h0, 32'h80FF7F01, 0, 1, 1, 4'h0, 32'h0, 32'h0));
        vecs.push_back(mk(1, 0, 3'b110, 32'h100, 32'h0, 32'h80FF7F01, 0, 1, 1, 4'h0, 32'h0, 32'h0));
        vecs.push_back(mk(1, 0, 3'b001, 32'h101, 32'h0, 32'h80FF7F01, 0, 1, 1, 4'h0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 1, 3'b001, 32'h103, 32'h1234, 32'h0, 0, 0, 1, 4'h0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 1, 3'b010, 32'h101, 32'h1234, 32'h0, 0, 0, 1, 4'h0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 1, 3'b011, 32'h100, 32'h1234, 32'h0, 0, 0, 1, 4'h0, 32'h0, 32'h0));
        vecs.push_back(mk(1, 1, 3'b010, 32'h104, 32'h01020304, 32'h0, 1, 0, 0, 4'hF, 32'h01020304, 32'h0));

        clear_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_stall", {31'b0, stall_m}, 32'h0);
        check("reset_req", {31'b0, dmem_req}, 32'h0);
        check("reset_fault", {31'b0, fault_m}, 32'h0);
        check("reset_readdata", readdata_m, 32'h0);
        check("reset_addr", dmem_addr, 32'h0);
        check("reset_be", {28'b0, dmem_be}, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset while waiting for rvalid: response is dropped.
        @(negedge clk);
        memread_m   = 1'b1;
        memwrite_m  = 1'b0;
        funct3_m    = 3'b010;
        aluresult_m = 32'h200;
        dmem_rdata  = 32'h11223344;
        dmem_gnt    = 1'b1;
        #1;
        check("rstmid_req", {31'b0, dmem_req}, 32'h1);
        check("rstmid_stall0", {31'b0, stall_m}, 32'h1);
        @(negedge clk);
        dmem_gnt = 1'b0;
        #1;
        check("rstmid_wait_stall", {31'b0, stall_m}, 32'h1);
        check("rstmid_wait_req", {31'b0, dmem_req}, 32'h0);
        rst       = 1'b1;
        memread_m = 1'b0;
        @(negedge clk);
        rst         = 1'b0;
        dmem_rvalid = 1'b1;
        #1;
        check("rstmid_after_stall", {31'b0, stall_m}, 32'h0);
        check("rstmid_after_req", {31'b0, dmem_req}, 32'h0);
        check("rstmid_after_rdata", readdata_m, 32'h0);
        @(negedge clk);
        dmem_rvalid = 1'b0;
        #1;
        check("rstmid_late_stall", {31'b0, stall_m}, 32'h0);
        check("rstmid_late_rdata", readdata_m, 32'h0);

        // Recovery: a fresh load completes normally.
        run_vec(100, mk(1, 0, 3'b010, 32'h204, 32'h0, 32'h11223344, 0, 1, 0, 4'h0, 32'h0, 32'h11223344));

        @(negedge clk);
        clear_inputs();
        #1;
        check("idle_stall", {31'b0, stall_m}, 32'h0);
        check("idle_req", {31'b0, dmem_req}, 32'h0);
        check("scoreboard_drained", sb_q.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
